// File: rtl/cpu_pkg.sv
// Shared CPU types and sizing constants for the load/store path.
package cpu_pkg;
   localparam int DW                  = 8;
   localparam int AW                  = 8;
   localparam int DEFAULT_MEM_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WB   = 2'd2
   } ldst_state_t;
endpackage

// File: rtl/ldst_unit_if.sv
// Data-memory req/ack bus between the load/store unit and memory.
interface ldst_unit_if #(
   parameter int AW = cpu_pkg::AW,
   parameter int DW = cpu_pkg::DW
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ldst_timer.sv
// Saturating down-counter: load a cycle budget, count down while enabled.
module ldst_timer #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          expired
);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (en && cnt != '0)  cnt <= cnt - CW'(1);
   end

   assign expired = (cnt == '0);
endmodule

// File: rtl/ldst_unit.sv
// Load/store sequencer: one req/ack memory transaction per start, with
// timeout abort and single-cycle register-file write-back for loads.
module ldst_unit #(
   parameter int AW      = cpu_pkg::AW,
   parameter int DW      = cpu_pkg::DW,
   parameter int TIMEOUT = cpu_pkg::DEFAULT_MEM_TIMEOUT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           is_store,
   input  logic           mov_dst,
   input  logic [AW-1:0]  addr,
   input  logic [DW-1:0]  wdata,
   input  logic           err_clr,
   ldst_unit_if.master    mem,
   output logic           rf_wr_en,
   output logic           rf_mov,
   output logic [DW-1:0]  rf_dat,
   output logic           stall,
   output logic           busy,
   output logic           err
);
   import cpu_pkg::*;

   localparam int CW = $clog2(TIMEOUT + 1);

   ldst_state_t   state, nxt;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, dat_q;
   logic          store_q, mov_q, err_q;
   logic          take, expired, timeout;

   assign take    = (state == IDLE) && start;
   assign timeout = (state == REQ) && !mem.ack && expired;

   // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th REQ cycle.
   ldst_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (take),
      .load_val (CW'(TIMEOUT - 1)),
      .en       (state == REQ),
      .expired  (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         store_q <= 1'b0;
         mov_q   <= 1'b0;
         dat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (take) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            store_q <= is_store;
            mov_q   <= mov_dst;
         end
         if (state == REQ && mem.ack && !store_q) dat_q <= mem.rdata;
         // Timeout set beats a coincident clear.
         if (timeout)      err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = REQ;
         REQ: begin
            if (mem.ack)      nxt = store_q ? IDLE : WB;
            else if (expired) nxt = IDLE;
         end
         WB:      nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      mem.req   = (state == REQ);
      mem.we    = (state == REQ) && store_q;
      mem.addr  = addr_q;
      mem.wdata = wdata_q;
      rf_wr_en  = (state == WB);
      rf_mov    = (state == WB) && mov_q;
      stall     = take || (state == REQ);
      busy      = (state != IDLE);
   end

   assign rf_dat = dat_q;
   assign err    = err_q;

   a_start_idle: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(start && state != IDLE));
endmodule

// File: tb/tb_ldst_unit.sv
// Directed bench for ldst_unit with a cycle-schedule model and per-cycle compare.
module tb_ldst_unit;
   localparam int TO = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, is_store, mov_dst, err_clr;
   logic [7:0] addr, wdata;
   logic       rf_wr_en, rf_mov, stall, busy, err;
   logic [7:0] rf_dat;

   ldst_unit_if mem_if ();

   ldst_unit #(.AW(8), .DW(8), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .is_store (is_store),
      .mov_dst  (mov_dst),
      .addr     (addr),
      .wdata    (wdata),
      .err_clr  (err_clr),
      .mem      (mem_if.master),
      .rf_wr_en (rf_wr_en),
      .rf_mov   (rf_mov),
      .rf_dat   (rf_dat),
      .stall    (stall),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int n_req = 0, n_stall = 0, n_wr = 0, n_mov = 0, n_busy = 0;

   // Expected outputs for the current cycle, plus persistent model state.
   logic       e_req, e_we, e_wr, e_mov, e_stall, e_busy, e_err;
   logic [7:0] e_addr, e_wdata, e_dat;
   logic       m_err;
   logic [7:0] m_dat;
   logic       chk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         check("mem_req",  32'(mem_if.req), 32'(e_req));
         check("busy",     32'(busy),       32'(e_busy));
         check("stall",    32'(stall),      32'(e_stall));
         check("rf_wr_en", 32'(rf_wr_en),   32'(e_wr));
         check("rf_mov",   32'(rf_mov),     32'(e_mov));
         check("rf_dat",   32'(rf_dat),     32'(e_dat));
         check("err",      32'(err),        32'(e_err));
         if (e_req) begin
            check("mem_we",    32'(mem_if.we),    32'(e_we));
            check("mem_addr",  32'(mem_if.addr),  32'(e_addr));
            check("mem_wdata", 32'(mem_if.wdata), 32'(e_wdata));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_if.req) n_req++;
         if (stall)      n_stall++;
         if (rf_wr_en)   n_wr++;
         if (rf_mov)     n_mov++;
         if (busy)       n_busy++;
      end
   end

   task automatic set_idle_exp();
      e_req = 0; e_we = 0; e_wr = 0; e_mov = 0; e_stall = 0; e_busy = 0;
      e_err = m_err; e_dat = m_dat;
   endtask

   task automatic idle(input int n, input bit junk_ack);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         start = 0; err_clr = 0;
         mem_if.ack = junk_ack; mem_if.rdata = 8'($urandom);
         set_idle_exp();
      end
   endtask

   task automatic clr_err();
      @(posedge clk); #1;
      start = 0; err_clr = 1; mem_if.ack = 0;
      set_idle_exp();
      m_err = 0;
      idle(1, 0);
   endtask

   // delay = REQ cycle (1-based) carrying the ack; 0 or > TO means no ack.
   task automatic txn(input bit st, input bit mv, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] rd, input int delay, input bit clr_last);
      bit acked;
      int r;
      acked = (delay >= 1 && delay <= TO);
      r     = acked ? delay : TO;
      @(posedge clk); #1;
      start = 1; is_store = st; mov_dst = mv; addr = a; wdata = wd;
      err_clr = 0; mem_if.ack = 0;
      set_idle_exp(); e_stall = 1;
      for (int i = 1; i <= r; i++) begin
         @(posedge clk); #1;
         start = 0; addr = 8'($urandom); wdata = 8'($urandom);
         mem_if.ack   = acked && (i == delay);
         mem_if.rdata = (acked && i == delay) ? rd : 8'($urandom);
         err_clr      = clr_last && (i == r) && !acked;
         set_idle_exp();
         e_req = 1; e_busy = 1; e_stall = 1;
         e_we = st; e_addr = a; e_wdata = wd;
      end
      if (!acked) m_err = 1;
      if (acked && !st) begin
         m_dat = rd;
         @(posedge clk); #1;
         mem_if.ack = 0; err_clr = 0;
         set_idle_exp();
         e_wr = 1; e_mov = mv; e_busy = 1;
      end
      idle(1, 0);
      @(negedge clk); #1;
   endtask

   initial begin
      int s_req, s_stall, s_wr, s_mov, s_busy;
      rst_n = 0; chk = 0;
      start = 0; is_store = 0; mov_dst = 0; err_clr = 0; addr = 0; wdata = 0;
      mem_if.ack = 0; mem_if.rdata = 0;
      m_err = 0; m_dat = 0;
      set_idle_exp();
      #3;
      check("rst_mem_req",  32'(mem_if.req), 32'(0));
      check("rst_busy",     32'(busy),       32'(0));
      check("rst_stall",    32'(stall),      32'(0));
      check("rst_rf_wr_en", 32'(rf_wr_en),   32'(0));
      check("rst_rf_dat",   32'(rf_dat),     32'(0));
      check("rst_err",      32'(err),        32'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1; chk = 1;
      idle(2, 0);

      s_stall = n_stall; s_wr = n_wr; s_req = n_req;
      txn(0, 0, 8'h3C, 8'h00, 8'hA5, 1, 0);
      check("ld1_stall_cycles", 32'(n_stall - s_stall), 32'(2));
      check("ld1_req_cycles",   32'(n_req - s_req),     32'(1));
      check("ld1_writes",       32'(n_wr - s_wr),       32'(1));
      check("ld1_rf_dat",       32'(rf_dat),            32'(8'hA5));

      s_req = n_req; s_wr = n_wr; s_busy = n_busy;
      txn(1, 0, 8'h10, 8'h7E, 8'h00, 4, 0);
      check("st4_req_cycles",  32'(n_req - s_req),   32'(4));
      check("st4_busy_cycles", 32'(n_busy - s_busy), 32'(4));
      check("st4_writes",      32'(n_wr - s_wr),     32'(0));

      idle(3, 1);

      s_req = n_req; s_wr = n_wr;
      txn(0, 0, 8'h55, 8'h00, 8'h99, 0, 0);
      check("to_req_cycles", 32'(n_req - s_req), 32'(15));
      check("to_writes",     32'(n_wr - s_wr),   32'(0));
      check("to_err",        32'(err),           32'(1));
      clr_err();
      check("clr_err", 32'(err), 32'(0));

      s_wr = n_wr;
      txn(0, 0, 8'h20, 8'h00, 8'hC3, 15, 0);
      check("ack15_err",    32'(err),         32'(0));
      check("ack15_writes", 32'(n_wr - s_wr), 32'(1));
      check("ack15_rf_dat", 32'(rf_dat),      32'(8'hC3));

      txn(1, 0, 8'h30, 8'h11, 8'h00, 0, 1);
      check("clr_vs_timeout_err", 32'(err), 32'(1));
      clr_err();

      s_wr = n_wr; s_mov = n_mov;
      txn(0, 1, 8'h44, 8'h00, 8'h42, 2, 0);
      check("mov_writes", 32'(n_wr - s_wr),   32'(1));
      check("mov_cycles", 32'(n_mov - s_mov), 32'(1));
      check("mov_rf_dat", 32'(rf_dat),        32'(8'h42));

      // Reset in the second REQ cycle of a load.
      @(posedge clk); #1;
      start = 1; is_store = 0; mov_dst = 0; addr = 8'h77; wdata = 8'h00; mem_if.ack = 0;
      set_idle_exp(); e_stall = 1;
      @(posedge clk); #1;
      start = 0;
      set_idle_exp(); e_req = 1; e_busy = 1; e_stall = 1; e_addr = 8'h77; e_wdata = 8'h00;
      @(posedge clk); #1;
      chk = 0;
      #1 rst_n = 0;
      #1;
      check("arst_mem_req",  32'(mem_if.req), 32'(0));
      check("arst_busy",     32'(busy),       32'(0));
      check("arst_stall",    32'(stall),      32'(0));
      check("arst_rf_wr_en", 32'(rf_wr_en),   32'(0));
      m_dat = 0; m_err = 0;
      @(posedge clk); #1;
      rst_n = 1;
      set_idle_exp(); chk = 1;
      s_wr = n_wr;
      idle(3, 0);
      @(negedge clk); #1;
      check("arst_no_write", 32'(n_wr - s_wr), 32'(0));

      s_wr = n_wr;
      txn(0, 0, 8'h66, 8'h00, 8'h5A, 3, 0);
      check("post_rst_writes", 32'(n_wr - s_wr), 32'(1));
      check("post_rst_rf_dat", 32'(rf_dat),      32'(8'h5A));

      chk = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
